// File: rtl/layer_pass_scheduler.sv
// rtl/layer_pass_scheduler.sv - sequences M/E/C tile passes of a conv layer for Controller_pass
module layer_pass_scheduler #(
    parameter int ADDR_BITS = 32,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_BITS-1:0]  num_m,
    input  logic [CNT_BITS-1:0]  num_e,
    input  logic [CNT_BITS-1:0]  num_c,
    input  logic [ADDR_BITS-1:0] ifmap_base,
    input  logic [ADDR_BITS-1:0] filter_base,
    input  logic [ADDR_BITS-1:0] bias_base,
    input  logic [ADDR_BITS-1:0] opsum_base,
    input  logic [ADDR_BITS-1:0] ifmap_e_step,
    input  logic [ADDR_BITS-1:0] ifmap_c_step,
    input  logic [ADDR_BITS-1:0] filter_m_step,
    input  logic [ADDR_BITS-1:0] filter_c_step,
    input  logic [ADDR_BITS-1:0] bias_m_step,
    input  logic [ADDR_BITS-1:0] opsum_m_step,
    input  logic [ADDR_BITS-1:0] opsum_e_step,
    input  logic                 pass_done,
    output logic                 pass_start,
    output logic [ADDR_BITS-1:0] ifmap_baseaddr,
    output logic [ADDR_BITS-1:0] filter_baseaddr,
    output logic [ADDR_BITS-1:0] bias_baseaddr,
    output logic [ADDR_BITS-1:0] opsum_baseaddr,
    output logic [ADDR_BITS-1:0] ipsum_baseaddr,
    output logic                 bias_ipsum_sel,
    output logic [CNT_BITS-1:0]  m_idx,
    output logic [CNT_BITS-1:0]  e_idx,
    output logic [CNT_BITS-1:0]  c_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DONE
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t state_q, state_d;

    // Latched layer configuration; counts are stored as last index (count-1, zero treated as one)
    logic [CNT_BITS-1:0]  m_last_q, m_last_d, e_last_q, e_last_d, c_last_q, c_last_d;
    logic [ADDR_BITS-1:0] ifmap_base_q, ifmap_base_d, filter_base_q, filter_base_d;
    logic [ADDR_BITS-1:0] bias_base_q, bias_base_d, opsum_base_q, opsum_base_d;
    logic [ADDR_BITS-1:0] ifmap_e_step_q, ifmap_e_step_d, ifmap_c_step_q, ifmap_c_step_d;
    logic [ADDR_BITS-1:0] filter_m_step_q, filter_m_step_d, filter_c_step_q, filter_c_step_d;
    logic [ADDR_BITS-1:0] bias_m_step_q, bias_m_step_d;
    logic [ADDR_BITS-1:0] opsum_m_step_q, opsum_m_step_d, opsum_e_step_q, opsum_e_step_d;

    // Tile indices, running addresses and tile origins used for rewinds
    logic [CNT_BITS-1:0]  m_idx_q, m_idx_d, e_idx_q, e_idx_d, c_idx_q, c_idx_d;
    logic [ADDR_BITS-1:0] ifmap_acc_q, ifmap_acc_d, filter_acc_q, filter_acc_d;
    logic [ADDR_BITS-1:0] bias_acc_q, bias_acc_d, opsum_acc_q, opsum_acc_d;
    logic [ADDR_BITS-1:0] ifmap_org_q, ifmap_org_d, filter_org_q, filter_org_d;
    logic [ADDR_BITS-1:0] opsum_org_q, opsum_org_d;

    function automatic logic [CNT_BITS-1:0] last_idx(input logic [CNT_BITS-1:0] n);
        return (n == '0) ? '0 : n - CNT_ONE;
    endfunction

    // Next-state, config latch, index advance and address accumulation
    always_comb begin
        state_d         = state_q;
        m_last_d        = m_last_q;
        e_last_d        = e_last_q;
        c_last_d        = c_last_q;
        ifmap_base_d    = ifmap_base_q;
        filter_base_d   = filter_base_q;
        bias_base_d     = bias_base_q;
        opsum_base_d    = opsum_base_q;
        ifmap_e_step_d  = ifmap_e_step_q;
        ifmap_c_step_d  = ifmap_c_step_q;
        filter_m_step_d = filter_m_step_q;
        filter_c_step_d = filter_c_step_q;
        bias_m_step_d   = bias_m_step_q;
        opsum_m_step_d  = opsum_m_step_q;
        opsum_e_step_d  = opsum_e_step_q;
        m_idx_d         = m_idx_q;
        e_idx_d         = e_idx_q;
        c_idx_d         = c_idx_q;
        ifmap_acc_d     = ifmap_acc_q;
        filter_acc_d    = filter_acc_q;
        bias_acc_d      = bias_acc_q;
        opsum_acc_d     = opsum_acc_q;
        ifmap_org_d     = ifmap_org_q;
        filter_org_d    = filter_org_q;
        opsum_org_d     = opsum_org_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d         = S_LOAD;
                    m_last_d        = last_idx(num_m);
                    e_last_d        = last_idx(num_e);
                    c_last_d        = last_idx(num_c);
                    ifmap_base_d    = ifmap_base;
                    filter_base_d   = filter_base;
                    bias_base_d     = bias_base;
                    opsum_base_d    = opsum_base;
                    ifmap_e_step_d  = ifmap_e_step;
                    ifmap_c_step_d  = ifmap_c_step;
                    filter_m_step_d = filter_m_step;
                    filter_c_step_d = filter_c_step;
                    bias_m_step_d   = bias_m_step;
                    opsum_m_step_d  = opsum_m_step;
                    opsum_e_step_d  = opsum_e_step;
                end
            end
            S_LOAD: begin
                state_d      = S_ISSUE;
                m_idx_d      = '0;
                e_idx_d      = '0;
                c_idx_d      = '0;
                ifmap_acc_d  = ifmap_base_q;
                filter_acc_d = filter_base_q;
                bias_acc_d   = bias_base_q;
                opsum_acc_d  = opsum_base_q;
                ifmap_org_d  = ifmap_base_q;
                filter_org_d = filter_base_q;
                opsum_org_d  = opsum_base_q;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (pass_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = S_ISSUE;
                if (c_idx_q != c_last_q) begin
                    c_idx_d      = c_idx_q + CNT_ONE;
                    ifmap_acc_d  = ifmap_acc_q + ifmap_c_step_q;
                    filter_acc_d = filter_acc_q + filter_c_step_q;
                end else if (e_idx_q != e_last_q) begin
                    c_idx_d      = '0;
                    e_idx_d      = e_idx_q + CNT_ONE;
                    ifmap_org_d  = ifmap_org_q + ifmap_e_step_q;
                    ifmap_acc_d  = ifmap_org_q + ifmap_e_step_q;
                    filter_acc_d = filter_org_q;
                    opsum_acc_d  = opsum_acc_q + opsum_e_step_q;
                end else if (m_idx_q != m_last_q) begin
                    c_idx_d      = '0;
                    e_idx_d      = '0;
                    m_idx_d      = m_idx_q + CNT_ONE;
                    ifmap_org_d  = ifmap_base_q;
                    ifmap_acc_d  = ifmap_base_q;
                    filter_org_d = filter_org_q + filter_m_step_q;
                    filter_acc_d = filter_org_q + filter_m_step_q;
                    bias_acc_d   = bias_acc_q + bias_m_step_q;
                    opsum_org_d  = opsum_org_q + opsum_m_step_q;
                    opsum_acc_d  = opsum_org_q + opsum_m_step_q;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset clears every output-visible value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            m_last_q        <= '0;
            e_last_q        <= '0;
            c_last_q        <= '0;
            ifmap_base_q    <= '0;
            filter_base_q   <= '0;
            bias_base_q     <= '0;
            opsum_base_q    <= '0;
            ifmap_e_step_q  <= '0;
            ifmap_c_step_q  <= '0;
            filter_m_step_q <= '0;
            filter_c_step_q <= '0;
            bias_m_step_q   <= '0;
            opsum_m_step_q  <= '0;
            opsum_e_step_q  <= '0;
            m_idx_q         <= '0;
            e_idx_q         <= '0;
            c_idx_q         <= '0;
            ifmap_acc_q     <= '0;
            filter_acc_q    <= '0;
            bias_acc_q      <= '0;
            opsum_acc_q     <= '0;
            ifmap_org_q     <= '0;
            filter_org_q    <= '0;
            opsum_org_q     <= '0;
        end else begin
            state_q         <= state_d;
            m_last_q        <= m_last_d;
            e_last_q        <= e_last_d;
            c_last_q        <= c_last_d;
            ifmap_base_q    <= ifmap_base_d;
            filter_base_q   <= filter_base_d;
            bias_base_q     <= bias_base_d;
            opsum_base_q    <= opsum_base_d;
            ifmap_e_step_q  <= ifmap_e_step_d;
            ifmap_c_step_q  <= ifmap_c_step_d;
            filter_m_step_q <= filter_m_step_d;
            filter_c_step_q <= filter_c_step_d;
            bias_m_step_q   <= bias_m_step_d;
            opsum_m_step_q  <= opsum_m_step_d;
            opsum_e_step_q  <= opsum_e_step_d;
            m_idx_q         <= m_idx_d;
            e_idx_q         <= e_idx_d;
            c_idx_q         <= c_idx_d;
            ifmap_acc_q     <= ifmap_acc_d;
            filter_acc_q    <= filter_acc_d;
            bias_acc_q      <= bias_acc_d;
            opsum_acc_q     <= opsum_acc_d;
            ifmap_org_q     <= ifmap_org_d;
            filter_org_q    <= filter_org_d;
            opsum_org_q     <= opsum_org_d;
        end
    end

    // Outputs decode straight from registers so reset clears them without waiting for a clock
    always_comb begin
        pass_start      = (state_q == S_ISSUE);
        done            = (state_q == S_DONE);
        busy            = (state_q != S_IDLE);
        ifmap_baseaddr  = ifmap_acc_q;
        filter_baseaddr = filter_acc_q;
        bias_baseaddr   = bias_acc_q;
        opsum_baseaddr  = opsum_acc_q;
        ipsum_baseaddr  = opsum_acc_q;
        bias_ipsum_sel  = (c_idx_q != '0);
        m_idx           = m_idx_q;
        e_idx           = e_idx_q;
        c_idx           = c_idx_q;
    end

endmodule
